mips_mem_arbiter: RTL and testbench

Arbiter and sequencer for the single shared 1024 x 32 word memory of the MIPS32 pipeline.
- Two requesters share the memory: the IF stage (instruction fetch, read only) and the MEM stage (LW/SW data access).
- The block serialises their accesses onto one variable-latency memory port and returns read data with one-cycle ack pulses.
- It drives a stall to the pipeline while any request is outstanding, and flags memory timeouts.

---
 rtl/mips32_pkg.sv | 13 +
 rtl/mips_mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mips_mem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 pipeline and its memory arbiter.
package mips32_pkg;

  localparam int MEM_AW = 10;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mips_mem_arbiter.sv
// Serialises IF fetches and MEM-stage loads/stores onto the single shared
// variable-latency memory port, with starvation guard and access timeout.
module mips_mem_arbiter
  import mips32_pkg::*;
#(
  parameter int AW           = MEM_AW,
  parameter int DW           = WORD_W,
  parameter int TIMEOUT      = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          pipe_stall,
  output logic          bus_err
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_e    state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_ack_q, if_ack_d;
  logic          dm_ack_q, dm_ack_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          bus_err_q, bus_err_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic if_v_s, dm_v_s, grant_if_s, grant_dm_s;

  // A requester whose ack is visible this cycle still shows its old req.
  assign if_v_s = if_req & ~if_ack_q;
  assign dm_v_s = dm_req & ~dm_ack_q;

  // Next-state logic for arbitration, access sequencing and counters.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    bus_err_d   = bus_err_q;
    starve_d    = starve_q;
    tmo_d       = tmo_q;
    grant_if_s  = 1'b0;
    grant_dm_s  = 1'b0;

    case (state_q)
      IDLE: begin
        tmo_d = {TW{1'b0}};
        if (if_v_s && (!dm_v_s || starve_q == STARVE_MAX)) begin
          grant_if_s = 1'b1;
        end else if (dm_v_s) begin
          grant_dm_s = 1'b1;
        end else begin
          grant_if_s = 1'b0;
        end

        if (grant_if_s) begin
          state_d     = BUSY_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = {DW{1'b0}};
          starve_d    = {SW{1'b0}};
        end else if (grant_dm_s) begin
          state_d     = BUSY_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          if (if_v_s && starve_q != STARVE_MAX) begin
            starve_d = starve_q + SW'(1);
          end else if (!if_req) begin
            starve_d = {SW{1'b0}};
          end else begin
            starve_d = starve_q;
          end
        end else if (!if_req) begin
          starve_d = {SW{1'b0}};
        end else begin
          starve_d = starve_q;
        end
      end

      BUSY_IF, BUSY_DM: begin
        tmo_d = tmo_q + TW'(1);
        if (mem_ack || tmo_q == TMO_LAST) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          tmo_d     = {TW{1'b0}};
          bus_err_d = bus_err_q | ~mem_ack;
          if (state_q == BUSY_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_ack ? mem_rdata : {DW{1'b0}};
          end else begin
            dm_ack_d = 1'b1;
            // Stores leave the last load result visible to the pipeline.
            if (!mem_we_q) begin
              dm_rdata_d = mem_ack ? mem_rdata : {DW{1'b0}};
            end else begin
              dm_rdata_d = dm_rdata_q;
            end
          end
        end else begin
          state_d = state_q;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        tmo_d     = {TW{1'b0}};
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {AW{1'b0}};
      mem_wdata_q <= {DW{1'b0}};
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= {DW{1'b0}};
      dm_rdata_q  <= {DW{1'b0}};
      bus_err_q   <= 1'b0;
      starve_q    <= {SW{1'b0}};
      tmo_q       <= {TW{1'b0}};
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      bus_err_q   <= bus_err_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign if_ack     = if_ack_q;
  assign dm_ack     = dm_ack_q;
  assign if_rdata   = if_rdata_q;
  assign dm_rdata   = dm_rdata_q;
  assign bus_err    = bus_err_q;
  assign pipe_stall = (if_req & ~if_ack_q) | (dm_req & ~dm_ack_q);

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction-level
// arbitration/latency model and a behavioural memory with random wait states.
module tb_mips_mem_arbiter;
  import mips32_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TIMEOUT = 16;
  localparam int STARVE_LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          pipe_stall;
  logic          bus_err;

  always #5 clk = ~clk;

  mips_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .pipe_stall(pipe_stall), .bus_err(bus_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [DW-1:0] mem_model [0:1023];
  int  cfg_wait  = 0;
  int  wait_left = 0;
  bit  mem_busy  = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and let the memory answer for the coming rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (mem_req) begin
      if (!mem_busy) begin
        mem_busy  = 1'b1;
        wait_left = cfg_wait;
      end
      if (wait_left == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_model[mem_addr];
        if (mem_we) mem_model[mem_addr] = mem_wdata;
        mem_busy  = 1'b0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        wait_left--;
      end
    end else begin
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      mem_busy  = 1'b0;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0;
    tick();
    check_val("rst_mem_req", mem_req, 1'b0);
    check_val("rst_acks", {if_ack, dm_ack}, 2'b00);
    check_val("rst_bus_err", bus_err, 1'b0);
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_rdata", {if_rdata, dm_rdata}, 0);
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  // Random-phase model state
  int  if_ack_at, dm_ack_at, busy_end, grant_pend, starve;
  bit  if_to, dm_to, dm_is_st, exp_err;
  logic [DW-1:0] if_val, dm_val, exp_dm_rd;

  initial begin
    logic [DW-1:0] keep;
    for (int i = 0; i < 1024; i++) mem_model[i] = $urandom;
    apply_reset();

    // 1: fetch with zero-wait memory
    mem_model[5] = 32'h0000_1234; cfg_wait = 0;
    if_req = 1'b1; if_addr = 10'd5;
    #1 check_val("t1_stall_c0", pipe_stall, 1'b1);
    tick();
    check_val("t1_mem_req", mem_req, 1'b1);
    check_val("t1_mem_addr", mem_addr, 10'd5);
    check_val("t1_mem_we", mem_we, 1'b0);
    check_val("t1_stall_c1", pipe_stall, 1'b1);
    check_val("t1_ack_c1", if_ack, 1'b0);
    tick();
    check_val("t1_ack_c2", if_ack, 1'b1);
    check_val("t1_rdata", if_rdata, 32'h0000_1234);
    check_val("t1_stall_c2", pipe_stall, 1'b0);
    if_req = 1'b0;
    tick();
    check_val("t1_ack_pulse", if_ack, 1'b0);

    // 2: simultaneous requests, DM first then IF after one idle cycle
    mem_model[7] = 32'hA5A5_0007; mem_model[3] = 32'h0000_3333;
    if_req = 1'b1; if_addr = 10'd3;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd7;
    tick();
    check_val("t2_first_addr", mem_addr, 10'd7);
    tick();
    check_val("t2_dm_ack", dm_ack, 1'b1);
    check_val("t2_dm_rdata", dm_rdata, 32'hA5A5_0007);
    check_val("t2_idle_gap", mem_req, 1'b0);
    check_val("t2_stall_idle", pipe_stall, 1'b1);
    dm_req = 1'b0;
    tick();
    check_val("t2_if_start", {mem_req, mem_addr}, {1'b1, 10'd3});
    tick();
    check_val("t2_if_ack", {if_ack, if_rdata}, {1'b1, 32'h0000_3333});
    if_req = 1'b0;
    tick();

    // 3: store with three wait cycles
    cfg_wait = 3;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd9; dm_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("t3_hold", {mem_req, mem_we, mem_addr, mem_wdata, dm_ack},
                {1'b1, 1'b1, 10'd9, 32'hDEAD_BEEF, 1'b0});
    end
    tick();
    check_val("t3_ack", dm_ack, 1'b1);
    check_val("t3_rdata_kept", dm_rdata, 32'hA5A5_0007);
    dm_req = 1'b0;
    tick();
    check_val("t3_ack_once", dm_ack, 1'b0);
    check_val("t3_no_err", bus_err, 1'b0);

    // 5: timeout, then sticky error through a good access
    cfg_wait = 1000;
    if_req = 1'b1; if_addr = 10'd11;
    for (int i = 0; i < TIMEOUT; i++) begin
      tick();
      check_val("t5_busy", {mem_req, if_ack}, 2'b10);
    end
    tick();
    check_val("t5_drop", mem_req, 1'b0);
    check_val("t5_ack", if_ack, 1'b1);
    check_val("t5_rdata0", if_rdata, 32'h0);
    check_val("t5_err", bus_err, 1'b1);
    if_req = 1'b0; cfg_wait = 0;
    tick();
    if_req = 1'b1; if_addr = 10'd5;
    tick();
    tick();
    check_val("t5_ok_ack", {if_ack, if_rdata}, {1'b1, 32'h0000_1234});
    check_val("t5_err_sticky", bus_err, 1'b1);
    if_req = 1'b0;
    tick();

    // 6: reset during a DM access, then re-arbitration
    cfg_wait = 10; keep = mem_model[2];
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd2;
    tick();
    tick();
    check_val("t6_busy", mem_req, 1'b1);
    #2 rst = 1'b1;
    #1 check_val("t6_async", {mem_req, dm_ack, bus_err}, 3'b000);
    cfg_wait = 0;
    tick();
    rst = 1'b0;
    tick();
    check_val("t6_rearb", {mem_req, mem_addr}, {1'b1, 10'd2});
    tick();
    check_val("t6_ack", {dm_ack, dm_rdata}, {1'b1, keep});
    dm_req = 1'b0;
    tick();

    // Randomized traffic against the arbitration/latency model
    apply_reset();
    if_ack_at = -1; dm_ack_at = -1; busy_end = 0; grant_pend = 0; starve = 0;
    exp_err = 1'b0; exp_dm_rd = '0;
    for (int n = 0; n < 3000; n++) begin
      bit if_done, dm_done, cand_if, cand_dm;
      int g, w, k;
      tick();
      if_done = (cyc == if_ack_at);
      dm_done = (cyc == dm_ack_at);

      if (grant_pend == 1)
        check_val("r_if_start", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, if_addr});
      else if (grant_pend == 2)
        check_val("r_dm_start", {mem_req, mem_we, mem_addr, (dm_we ? mem_wdata : 32'h0)},
                  {1'b1, dm_we, dm_addr, (dm_we ? dm_wdata : 32'h0)});
      check_val("r_mem_req", mem_req, cyc < busy_end);
      check_val("r_if_ack", if_ack, if_done);
      check_val("r_dm_ack", dm_ack, dm_done);
      if (if_done) begin
        if (if_to) exp_err = 1'b1;
        check_val("r_if_rdata", if_rdata, if_val);
      end
      if (dm_done) begin
        if (dm_to) exp_err = 1'b1;
        if (!dm_is_st) exp_dm_rd = dm_val;
        check_val("r_dm_rdata", dm_rdata, exp_dm_rd);
      end
      check_val("r_bus_err", bus_err, exp_err);
      check_val("r_stall", pipe_stall, (if_req && !if_done) || (dm_req && !dm_done));

      // Requesters: hold until ack, sometimes re-request straight away
      if (if_done || !if_req) begin
        if_req = ($urandom_range(0, 2) == 0);
        if_addr = 10'($urandom);
      end
      if (dm_done || !dm_req) begin
        dm_req = ($urandom_range(0, 2) == 0);
        dm_we = 1'($urandom_range(0, 1));
        dm_addr = 10'($urandom);
        dm_wdata = $urandom;
      end
      cand_if = if_req && !if_done;
      cand_dm = dm_req && !dm_done;

      grant_pend = 0;
      if (cyc >= busy_end) begin
        g = 0;
        if (cand_if && (!cand_dm || starve == STARVE_LIMIT)) g = 1;
        else if (cand_dm) g = 2;
        if (g == 1) starve = 0;
        else if (g == 2 && cand_if) starve = (starve < STARVE_LIMIT) ? starve + 1 : starve;
        else if (!if_req) starve = 0;
        if (g != 0) begin
          case ($urandom_range(0, 19))
            0:       w = TIMEOUT + 4;
            1:       w = TIMEOUT - 1;
            default: w = $urandom_range(0, 3);
          endcase
          cfg_wait = w;
          k = (w > TIMEOUT - 1) ? TIMEOUT - 1 : w;
          busy_end = cyc + k + 2;
          grant_pend = g;
          if (g == 1) begin
            if_ack_at = busy_end; if_to = (w >= TIMEOUT);
            if_val = if_to ? 32'h0 : mem_model[if_addr];
          end else begin
            dm_ack_at = busy_end; dm_to = (w >= TIMEOUT); dm_is_st = dm_we;
            dm_val = dm_to ? 32'h0 : mem_model[dm_addr];
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
